buffer_byte_streamer: RTL and testbench
=======================================

Name: buffer_byte_streamer

Overview:
- Read-side engine for the byte-addressable 64-bit word buffer.
- Given a start byte address and a byte count, issues 64-bit word reads on the buffer's word port and emits the bytes one at a time on a valid/ready stream toward the compute datapath.
- Single-word prefetch sustains 1 byte/cycle. Completion is signalled with out_last and a done pulse.

Parameters:
BuffDepth, 256, buffer size in bytes (power of two, ≥16)
ByteAddrW, $clog2(BuffDepth), byte address width
WordDepth, BuffDepth/8, buffer size in 64-bit words
WordAddrW, $clog2(WordDepth), word address width
CntW, ByteAddrW+1, byte count width (counts 0..BuffDepth)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only when busy=0
start_byte_addr  in  ByteAddrW  first byte to stream
byte_count  in  CntW  bytes to stream (0..BuffDepth)
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
buf_read_en  out  1  word read strobe to buffer
buf_word_addr  out  WordAddrW  word address for the read
buf_word_rdata  in  64  buffer read data, valid the cycle after buf_read_en
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts out_byte
out_byte  out  8  streamed byte
out_last  out  1  out_byte is the final byte of the transfer

Behaviour:
- Reset (async, rst_n=0):
  - Outputs busy, done, buf_read_en, out_valid and out_last go to 0; out_byte, buf_word_addr go to 0.
  - FSM goes to IDLE; prefetch valid flag is cleared.
  - Read data still in flight is discarded.
- Byte order: little-endian. Byte k of a word is bits [8k+7:8k]; byte address a maps to word a>>3, lane a[2:0].
- Addresses advance modulo BuffDepth: byte BuffDepth-1 is followed by byte 0, word WordDepth-1 by word 0.
- FSM states: IDLE, FETCH, WAIT, STREAM, DONE.
  - IDLE:
    - start=1 and byte_count≠0: latch address and count, busy=1, go to FETCH.
    - start=1 and byte_count=0: go to DONE with no buffer access.
  - FETCH: buf_read_en=1, buf_word_addr=start word. Go to WAIT.
  - WAIT: capture buf_word_rdata into cur_word at end of cycle. Go to STREAM.
  - STREAM:
    - out_valid=1 while cur_word holds unsent bytes.
    - A byte is consumed only on out_valid & out_ready. out_byte and out_last stay stable while out_ready=0.
    - When the final byte is consumed, go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE. busy is 1 from the cycle after accepted start through the last STREAM cycle.
- First-byte latency: start at cycle 0, buf_read_en at cycle 1, out_valid at cycle 3.
- Prefetch (next-word holding register nxt_word):
  - buf_read_en=1 in a STREAM cycle when all three hold: nxt not valid, no read in flight, and unfetched words remain.
  - Data is captured into nxt_word the following cycle.
  - When the last lane of cur_word is consumed and nxt is valid, nxt moves to cur in the same edge, so there is no bubble.
  - If nxt is not yet valid at that point, out_valid=0 until it arrives (bubble). This occurs only when the first word supplies a single byte (start lane 7).
- Buffer reads: at most one per word touched; never more than one outstanding.
- start while busy=1 or in DONE: ignored, no effect.
- out_last=1 exactly with the final byte; it is never asserted for a count-0 transfer.

Decomposition:
- Shared package buffer_pkg:
  - streamer FSM state enum
  - byte-lane width constant (8) and lanes-per-word constant (8)
  - word/byte address conversion function
- One sub-module: word_prefetch_reg.
  - Contains the cur/nxt 64-bit registers, valid flags, lane counter and lane mux.
  - Takes load/shift controls from the FSM.

Test Plan:
Buffer preloaded so byte i = i[7:0]; word 0 = 0x0706050403020100.
1. start addr 0, count 8, out_ready=1 -> bytes 0x00..0x07 on cycles 3..10, out_last with 0x07, done on cycle 11, exactly one buf_read_en (word 0).
2. start addr 7, count 3, out_ready=1 -> 0x07 at cycle 3, out_valid=0 at cycle 4, 0x08 and 0x09 at cycles 5–6 (last on 0x09), reads of words 0 and 1.
3. start addr 254, count 4 -> bytes 0xFE, 0xFF, 0x00, 0x01, reads of word 31 then word 0, out_last on 0x01.
4. addr 0, count 16, out_ready=0 on cycles 4–6 -> 0x01 held stable cycles 4–7, no byte lost or duplicated, 16 bytes total, 2 reads.
5. count 0 -> done=1 on cycle 1, busy stays 0, no buf_read_en, no out_valid; a start during busy of a count-8 run is ignored (8 bytes only).
6. rst_n=0 mid-stream (after 3 bytes) -> out_valid, busy, buf_read_en drop immediately; after release, a new start addr 8 count 2 yields 0x08, 0x09 normally.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared definitions for the byte-addressable 64-bit word buffer read path.
//   - strm_state_e : streamer FSM states
//   - ByteLaneW    : bits per byte lane
//   - LanesPerWord : byte lanes per 64-bit word
//   - byte_to_word / byte_to_lane : little-endian byte address split
package buffer_pkg;

    localparam int unsigned ByteLaneW    = 8;
    localparam int unsigned LanesPerWord = 8;
    localparam int unsigned LaneIdxW     = $clog2(LanesPerWord);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StStream,
        StDone
    } strm_state_e;

    // Word index holding a byte; callers truncate to their word address width.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> LaneIdxW;
    endfunction

    // Byte lane within its word (byte k sits at bits [8k+7:8k]).
    function automatic logic [LaneIdxW-1:0] byte_to_lane(input logic [31:0] byte_addr);
        return LaneIdxW'(byte_addr & 32'(LanesPerWord - 1));
    endfunction

endpackage

// File: rtl/word_prefetch_reg.sv
// Current/next 64-bit word holding registers with lane counter and lane mux.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clr          : drop both words (end of transfer)
//   load_cur     : load rdata into cur_word, lane counter <= lane_init
//   lane_init    : first lane of the transfer
//   load_nxt     : prefetched rdata is arriving this cycle
//   rdata        : buffer read data
//   shift        : current byte consumed, advance one lane
//   cur_valid    : cur_word holds unsent bytes
//   nxt_valid    : nxt_word holds a prefetched word
//   lane_byte    : byte at the current lane of cur_word
module word_prefetch_reg
    import buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load_cur,
    input  logic [LaneIdxW-1:0]  lane_init,
    input  logic                 load_nxt,
    input  logic [63:0]          rdata,
    input  logic                 shift,
    output logic                 cur_valid,
    output logic                 nxt_valid,
    output logic [ByteLaneW-1:0] lane_byte
);

    logic [63:0]         cur_word_q, cur_word_d;
    logic [63:0]         nxt_word_q, nxt_word_d;
    logic                cur_valid_q, cur_valid_d;
    logic                nxt_valid_q, nxt_valid_d;
    logic [LaneIdxW-1:0] lane_q, lane_d;
    logic                last_lane;

    always_comb begin
        cur_word_d  = cur_word_q;
        nxt_word_d  = nxt_word_q;
        cur_valid_d = cur_valid_q;
        nxt_valid_d = nxt_valid_q;
        lane_d      = lane_q;
        last_lane   = (lane_q == LaneIdxW'(LanesPerWord - 1));

        if (clr) begin
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
            lane_d      = '0;
        end else if (load_cur) begin
            cur_word_d  = rdata;
            cur_valid_d = 1'b1;
            nxt_valid_d = 1'b0;
            lane_d      = lane_init;
        end else begin
            if (shift) begin
                if (last_lane) begin
                    lane_d = '0;
                    // Hand over the prefetched word on the same edge: no bubble.
                    if (nxt_valid_q) begin
                        cur_word_d  = nxt_word_q;
                        cur_valid_d = 1'b1;
                        nxt_valid_d = 1'b0;
                    end else begin
                        cur_valid_d = 1'b0;
                    end
                end else begin
                    lane_d = lane_q + LaneIdxW'(1);
                end
            end
            // Arriving word goes straight to cur if cur is (or is becoming) empty,
            // otherwise it parks in nxt.
            if (load_nxt) begin
                if (!cur_valid_q || (shift && last_lane && !nxt_valid_q)) begin
                    cur_word_d  = rdata;
                    cur_valid_d = 1'b1;
                    lane_d      = '0;
                end else begin
                    nxt_word_d  = rdata;
                    nxt_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_word_q  <= '0;
            nxt_word_q  <= '0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            lane_q      <= '0;
        end else begin
            cur_word_q  <= cur_word_d;
            nxt_word_q  <= nxt_word_d;
            cur_valid_q <= cur_valid_d;
            nxt_valid_q <= nxt_valid_d;
            lane_q      <= lane_d;
        end
    end

    assign cur_valid = cur_valid_q;
    assign nxt_valid = nxt_valid_q;
    assign lane_byte = cur_word_q[{lane_q, 3'b000} +: ByteLaneW];

endmodule

// File: rtl/buffer_byte_streamer.sv
// Read-side engine for the byte-addressable 64-bit word buffer. Reads words on
// the buffer word port and streams the requested bytes one per cycle on a
// valid/ready interface, with a single-word prefetch.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   start, start_byte_addr,
//   byte_count                     : transfer request (sampled only when idle)
//   busy, done                     : transfer in progress / one-cycle end pulse
//   buf_read_en, buf_word_addr,
//   buf_word_rdata                 : buffer word port (data one cycle after read)
//   out_valid, out_ready,
//   out_byte, out_last             : byte stream toward the datapath
module buffer_byte_streamer
    import buffer_pkg::*;
#(
    parameter int unsigned BuffDepth = 256,
    parameter int unsigned ByteAddrW = $clog2(BuffDepth),
    parameter int unsigned WordDepth = BuffDepth / 8,
    parameter int unsigned WordAddrW = $clog2(WordDepth),
    parameter int unsigned CntW      = ByteAddrW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ByteAddrW-1:0] start_byte_addr,
    input  logic [CntW-1:0]      byte_count,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_read_en,
    output logic [WordAddrW-1:0] buf_word_addr,
    input  logic [63:0]          buf_word_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 out_last
);

    localparam int unsigned SumW = CntW + 1;

    strm_state_e         state_q, state_d;
    logic [WordAddrW-1:0] fetch_addr_q, fetch_addr_d;  // next word to read
    logic [CntW-1:0]      words_left_q, words_left_d;  // words not yet read
    logic [CntW-1:0]      bytes_left_q, bytes_left_d;  // bytes not yet consumed
    logic [LaneIdxW-1:0]  start_lane_q, start_lane_d;
    logic                 inflight_q, inflight_d;

    logic                 cur_valid;
    logic                 nxt_valid;
    logic [7:0]           lane_byte;
    logic                 pf_issue;
    logic                 consume;
    logic [SumW-1:0]      words_sum;

    // Words touched = ceil((start lane + count) / 8).
    assign words_sum = SumW'(byte_to_lane(32'(start_byte_addr))) + SumW'(byte_count)
                     + SumW'(LanesPerWord - 1);

    assign out_valid = (state_q == StStream) && cur_valid;
    assign consume   = out_valid && out_ready;
    assign out_last  = out_valid && (bytes_left_q == CntW'(1));
    assign out_byte  = lane_byte;

    // One read outstanding at most, and only when the holding slot is free.
    assign pf_issue = (state_q == StStream) && !nxt_valid && !inflight_q
                    && (words_left_q != '0);

    assign buf_read_en   = (state_q == StFetch) || pf_issue;
    assign buf_word_addr = fetch_addr_q;
    assign busy          = (state_q == StFetch) || (state_q == StWait)
                         || (state_q == StStream);
    assign done          = (state_q == StDone);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        words_left_d = words_left_q;
        bytes_left_d = bytes_left_q;
        start_lane_d = start_lane_q;
        inflight_d   = pf_issue;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (byte_count != '0) begin
                        fetch_addr_d = WordAddrW'(byte_to_word(32'(start_byte_addr)));
                        start_lane_d = byte_to_lane(32'(start_byte_addr));
                        bytes_left_d = byte_count;
                        words_left_d = CntW'(words_sum >> LaneIdxW);
                        state_d      = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFetch: begin
                fetch_addr_d = fetch_addr_q + WordAddrW'(1);
                words_left_d = words_left_q - CntW'(1);
                state_d      = StWait;
            end
            StWait: begin
                state_d = StStream;
            end
            StStream: begin
                if (pf_issue) begin
                    fetch_addr_d = fetch_addr_q + WordAddrW'(1);
                    words_left_d = words_left_q - CntW'(1);
                end
                if (consume) begin
                    bytes_left_d = bytes_left_q - CntW'(1);
                    if (bytes_left_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_addr_q <= '0;
            words_left_q <= '0;
            bytes_left_q <= '0;
            start_lane_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            words_left_q <= words_left_d;
            bytes_left_q <= bytes_left_d;
            start_lane_q <= start_lane_d;
            inflight_q   <= inflight_d;
        end
    end

    word_prefetch_reg u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q == StDone),
        .load_cur  (state_q == StWait),
        .lane_init (start_lane_q),
        .load_nxt  (inflight_q),
        .rdata     (buf_word_rdata),
        .shift     (consume),
        .cur_valid (cur_valid),
        .nxt_valid (nxt_valid),
        .lane_byte (lane_byte)
    );

endmodule

// File: tb/tb_buffer_byte_streamer.sv
// Directed bench for buffer_byte_streamer. Buffer model holds byte i = i[7:0].
module tb_buffer_byte_streamer;

    localparam int unsigned BuffDepth = 256;
    localparam int unsigned ByteAddrW = 8;
    localparam int unsigned WordAddrW = 5;
    localparam int unsigned CntW      = 9;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [ByteAddrW-1:0] start_byte_addr;
    logic [CntW-1:0]      byte_count;
    logic                 busy;
    logic                 done;
    logic                 buf_read_en;
    logic [WordAddrW-1:0] buf_word_addr;
    logic [63:0]          buf_word_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_byte;
    logic                 out_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]           got_b[$];
    logic                 got_l[$];
    logic [WordAddrW-1:0] got_rd[$];
    logic                 rd_en_s;
    logic [WordAddrW-1:0] rd_addr_s;

    buffer_byte_streamer #(
        .BuffDepth (BuffDepth)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_byte_addr (start_byte_addr),
        .byte_count      (byte_count),
        .busy            (busy),
        .done            (done),
        .buf_read_en     (buf_read_en),
        .buf_word_addr   (buf_word_addr),
        .buf_word_rdata  (buf_word_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_byte        (out_byte),
        .out_last        (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [WordAddrW-1:0] w);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = {w, 3'(k)};
        return r;
    endfunction

    // Observe on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        rd_en_s   <= buf_read_en;
        rd_addr_s <= buf_word_addr;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_b.push_back(out_byte);
                got_l.push_back(out_last);
            end
            if (buf_read_en) got_rd.push_back(buf_word_addr);
        end
    end

    always @(posedge clk) begin
        buf_word_rdata <= rd_en_s ? mem_word(rd_addr_s) : 64'hA5A5_A5A5_A5A5_A5A5;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_b.delete();
        got_l.delete();
        got_rd.delete();
    endtask

    // Pulse start, then wait (bounded) for the done cycle; returns in that cycle.
    task automatic run_xfer(input logic [7:0] a, input logic [8:0] c, input string tag);
        int n;
        start = 1'b1;
        start_byte_addr = a;
        byte_count = c;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        logic [7:0] exp3[4];
        exp3[0] = 8'hFE; exp3[1] = 8'hFF; exp3[2] = 8'h00; exp3[3] = 8'h01;

        rst_n = 1'b0;
        start = 1'b0;
        start_byte_addr = '0;
        byte_count = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", buf_read_en, 0);
        chk("rst_waddr", buf_word_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_byte", out_byte, 0);
        rst_n = 1'b1;
        tick();

        // 1: aligned 8 bytes
        clear_q();
        start = 1'b1; start_byte_addr = 8'd0; byte_count = 9'd8;
        chk("t1_c0_busy", busy, 0);
        tick();
        start = 1'b0;
        chk("t1_c1_rden", buf_read_en, 1);
        chk("t1_c1_addr", buf_word_addr, 0);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_valid", out_valid, 0);
        tick();
        chk("t1_c2_rden", buf_read_en, 0);
        chk("t1_c2_valid", out_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("t1_valid", out_valid, 1);
            chk("t1_byte", out_byte, k);
            chk("t1_last", out_last, (k == 7));
            tick();
        end
        chk("t1_c11_done", done, 1);
        chk("t1_c11_busy", busy, 0);
        chk("t1_c11_valid", out_valid, 0);
        tick();
        chk("t1_c12_done", done, 0);
        chk("t1_nreads", got_rd.size(), 1);
        chk("t1_rd0", got_rd[0], 0);
        chk("t1_nbytes", got_b.size(), 8);

        // 2: start lane 7, bubble before second word
        clear_q();
        start = 1'b1; start_byte_addr = 8'd7; byte_count = 9'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t2_c3_valid", out_valid, 1);
        chk("t2_c3_byte", out_byte, 8'h07);
        chk("t2_c3_last", out_last, 0);
        tick();
        chk("t2_c4_bubble", out_valid, 0);
        tick();
        chk("t2_c5_valid", out_valid, 1);
        chk("t2_c5_byte", out_byte, 8'h08);
        chk("t2_c5_last", out_last, 0);
        tick();
        chk("t2_c6_byte", out_byte, 8'h09);
        chk("t2_c6_last", out_last, 1);
        tick();
        chk("t2_c7_done", done, 1);
        tick();
        chk("t2_nreads", got_rd.size(), 2);
        chk("t2_rd0", got_rd[0], 0);
        chk("t2_rd1", got_rd[1], 1);

        // 3: wrap past the top of the buffer
        clear_q();
        run_xfer(8'd254, 9'd4, "t3");
        tick();
        chk("t3_nbytes", got_b.size(), 4);
        for (int i = 0; i < 4 && i < got_b.size(); i++) begin
            chk("t3_byte", got_b[i], exp3[i]);
            chk("t3_last", got_l[i], (i == 3));
        end
        chk("t3_nreads", got_rd.size(), 2);
        if (got_rd.size() == 2) begin
            chk("t3_rd0", got_rd[0], 31);
            chk("t3_rd1", got_rd[1], 0);
        end

        // 4: backpressure on cycles 4..6
        clear_q();
        start = 1'b1; start_byte_addr = 8'd0; byte_count = 9'd16;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t4_c3_byte", out_byte, 8'h00);
        tick();
        out_ready = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_byte", out_byte, 8'h01);
            chk("t4_hold_last", out_last, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("t4_c7_byte", out_byte, 8'h01);
        begin
            int n;
            n = 0;
            while (!done && n < 100) begin
                tick();
                n++;
            end
        end
        chk("t4_done", done, 1);
        tick();
        chk("t4_nbytes", got_b.size(), 16);
        for (int i = 0; i < 16 && i < got_b.size(); i++) begin
            chk("t4_byte", got_b[i], i);
            chk("t4_last", got_l[i], (i == 15));
        end
        chk("t4_nreads", got_rd.size(), 2);

        // 5a: zero-length transfer
        clear_q();
        start = 1'b1; start_byte_addr = 8'h10; byte_count = 9'd0;
        chk("t5_c0_busy", busy, 0);
        tick();
        start = 1'b0;
        chk("t5_c1_done", done, 1);
        chk("t5_c1_busy", busy, 0);
        chk("t5_c1_rden", buf_read_en, 0);
        chk("t5_c1_valid", out_valid, 0);
        chk("t5_c1_last", out_last, 0);
        tick();
        chk("t5_c2_done", done, 0);
        chk("t5_c2_busy", busy, 0);
        chk("t5_nreads", got_rd.size(), 0);
        chk("t5_nbytes", got_b.size(), 0);

        // 5b: start while busy and in DONE is ignored
        clear_q();
        start = 1'b1; start_byte_addr = 8'd0; byte_count = 9'd8;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; start_byte_addr = 8'd16; byte_count = 9'd4;
        tick();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 100) begin
                tick();
                n++;
            end
        end
        chk("t5b_done", done, 1);
        start = 1'b1; start_byte_addr = 8'd16; byte_count = 9'd4;
        tick();
        start = 1'b0;
        chk("t5b_after_done_busy", busy, 0);
        tick();
        chk("t5b_idle_busy", busy, 0);
        chk("t5b_nbytes", got_b.size(), 8);
        chk("t5b_nreads", got_rd.size(), 1);
        if (got_b.size() == 8) chk("t5b_lastbyte", got_b[7], 8'h07);

        // 6: reset mid-stream, then a clean transfer
        clear_q();
        start = 1'b1; start_byte_addr = 8'd0; byte_count = 9'd16;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        chk("t6_pre_nbytes", got_b.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rden", buf_read_en, 0);
        chk("t6_rst_last", out_last, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
        run_xfer(8'd8, 9'd2, "t6");
        tick();
        chk("t6_nbytes", got_b.size(), 2);
        if (got_b.size() == 2) begin
            chk("t6_b0", got_b[0], 8'h08);
            chk("t6_b1", got_b[1], 8'h09);
            chk("t6_l0", got_l[0], 0);
            chk("t6_l1", got_l[1], 1);
        end
        chk("t6_nreads", got_rd.size(), 1);
        if (got_rd.size() == 1) chk("t6_rd0", got_rd[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
